fetch_stage: RTL and testbench

//   Instruction fetch front end for the RV32I core; the producer side of the decode stage's

---
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I fetch front end; one outstanding req/gnt/rvalid word fetch,
//            presents instr/PC/valid to decode and applies next-PC selection.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] program_counter,
    output logic        valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;
    logic        r_misalign;
    logic [31:0] r_count;
    logic [31:0] w_next_pc;
    logic        w_load;
    logic        w_consume;
    logic        w_aligned;

    assign w_next_pc = redirect ? redirect_pc : r_fetch_pc + 32'd4;
    assign w_aligned = (w_next_pc[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // rvalid is only honoured in WAIT, so stale responses after reset are dropped
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            S_IDLE: w_next_state = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_load       = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_consume    = 1'b1;
                    w_next_state = w_aligned ? S_REQ : S_ERR;
                end
            end
            S_ERR:   w_next_state = S_ERR;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_instr    <= c_NOP;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= 32'd0;
        end else begin
            if (w_load) begin
                r_instr <= imem_rdata;
                r_pc    <= r_fetch_pc;
                r_valid <= 1'b1;
            end
            if (w_consume) begin
                r_count <= r_count + 32'd1;
                r_valid <= 1'b0;
                if (w_aligned) begin
                    r_fetch_pc <= w_next_pc;
                end else begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

    assign imem_req        = (r_state == S_REQ);
    assign imem_addr       = r_fetch_pc;
    assign instr           = r_instr;
    assign program_counter = r_pc;
    assign valid           = r_valid;
    assign misalign_err    = r_misalign;
    assign fetch_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Scoreboard bench for fetch_stage; directed fetch/stall/redirect,
//            misalign and mid-transaction reset sequences.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] program_counter;
    logic        valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_count;
    logic        prev_valid;
    logic [63:0] sb_q[$];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .program_counter (program_counter),
        .valid           (valid),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word returned by the memory model for a given address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each new valid presentation is matched against the scoreboard
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h instr %h expected no valid", program_counter, instr);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                if ({instr, program_counter} !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got instr %h pc %h expected instr %h pc %h",
                             instr, program_counter, e[63:32], e[31:0]);
                end
            end
        end
        prev_valid = valid;
    end

    // Serve one fetch of address a, holding gnt low for gdly REQ cycles first
    task automatic fetch(input logic [31:0] a, input int gdly);
        int t;
        t = 0;
        while (!imem_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        check("req_addr", imem_addr, a);
        for (int i = 0; i < gdly; i++) begin
            @(negedge clk);
            check("req_hold", {31'd0, imem_req}, 32'd1);
            check("addr_hold", imem_addr, a);
        end
        imem_gnt = 1'b1;
        @(posedge clk);
        #1 imem_gnt = 1'b0;
        @(negedge clk);
        check("wait_noreq", {31'd0, imem_req}, 32'd0);
        check("wait_novalid", {31'd0, valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
        sb_q.push_back({mem_word(a), a});
        @(posedge clk);
        #1 imem_rvalid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
    endtask

    // In HOLD at epc: stall for nstall cycles (optionally with redirect asserted), then consume
    task automatic consume(input logic [31:0] epc, input int nstall, input logic rd_in_stall,
                           input logic redir, input logic [31:0] rpc);
        check("hold_valid", {31'd0, valid}, 32'd1);
        for (int i = 0; i < nstall; i++) begin
            stall       = 1'b1;
            redirect    = rd_in_stall;
            redirect_pc = 32'h0000_0200;
            @(negedge clk);
            check("stall_valid", {31'd0, valid}, 32'd1);
            check("stall_instr", instr, mem_word(epc));
            check("stall_pc", program_counter, epc);
            check("stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        stall       = 1'b0;
        redirect    = redir;
        redirect_pc = rpc;
        @(posedge clk);
        #1 redirect = 1'b0;
        exp_count = exp_count + 32'd1;
        @(negedge clk);
        check("consumed_valid", {31'd0, valid}, 32'd0);
        check("fetch_count", fetch_count, exp_count);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_pc"}, program_counter, 32'h0);
        check({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
        check({tag, "_count"}, fetch_count, 32'd0);
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        exp_count   = 32'd0;
        prev_valid  = 1'b0;
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        check("rst_instr", instr, 32'h0000_0013);
        rst = 1'b1;

        // Sequential fetch at minimum cadence
        fetch(32'h0, 0);
        consume(32'h0, 0, 1'b0, 1'b0, 32'h0);
        fetch(32'h4, 0);
        consume(32'h4, 0, 1'b0, 1'b0, 32'h0);
        fetch(32'h8, 0);
        consume(32'h8, 0, 1'b0, 1'b0, 32'h0);
        check("count_after3", fetch_count, 32'd3);

        // Grant held off for 5 REQ cycles
        fetch(32'hC, 5);
        consume(32'hC, 0, 1'b0, 1'b0, 32'h0);

        // Stall 4 cycles in HOLD at 0x10
        fetch(32'h10, 0);
        consume(32'h10, 4, 1'b0, 1'b0, 32'h0);
        check("count_after_stall", fetch_count, 32'd5);
        fetch(32'h14, 0);
        consume(32'h14, 0, 1'b0, 1'b0, 32'h0);
        fetch(32'h18, 0);
        consume(32'h18, 0, 1'b0, 1'b0, 32'h0);
        fetch(32'h1C, 0);
        consume(32'h1C, 0, 1'b0, 1'b0, 32'h0);

        // Redirect at 0x20; redirect while stalled is ignored
        fetch(32'h20, 0);
        consume(32'h20, 2, 1'b1, 1'b1, 32'h0000_0100);
        fetch(32'h100, 1);

        // Misaligned redirect target enters the sticky error state
        consume(32'h100, 0, 1'b0, 1'b1, 32'h0000_0102);
        check("misalign_set", {31'd0, misalign_err}, 32'd1);
        check("count_after_err", fetch_count, 32'd10);
        imem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("err_noreq", {31'd0, imem_req}, 32'd0);
            check("err_novalid", {31'd0, valid}, 32'd0);
            check("err_sticky", {31'd0, misalign_err}, 32'd1);
        end
        imem_gnt = 1'b0;

        // Reset out of ERR, then reset again while a response is outstanding
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_count = 32'd0;
        while (!imem_req) @(negedge clk);
        imem_gnt = 1'b1;
        @(posedge clk);
        #1 imem_gnt = 1'b0;
        @(negedge clk);
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0001;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check_reset_state("midrst");
        rst = 1'b1;
        imem_rvalid = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("post_rst_valid", {31'd0, valid}, 32'd0);
        fetch(32'h0, 0);
        consume(32'h0, 0, 1'b0, 1'b0, 32'h0);
        check("post_rst_count", fetch_count, 32'd1);

        repeat (2) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
